intra16_mode_sched: RTL and testbench

- Sequencer and mode-decision controller for the luma 16x16 intra SAD datapath.
- Accepts one 16-sample residual row per beat for the V, H and DC candidate predictions, over 16 beats, through a valid/ready handshake.
- Accumulates per-mode absolute-residual sums in full precision, masks modes whose neighbours are unavailable, and reports the winning mode and its SAD with a done pulse.
- Sits between the intra predictor/residual generator and the macroblock mode-decision logic.

---
 rtl/intra16_mode_sched.sv | 171 +++++++++++++++++
 tb/tb_intra16_mode_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/intra16_mode_sched.sv
// Luma 16x16 intra SAD sequencer: accumulates per-mode absolute residual sums and picks the cheapest mode.
// Optional plane-mode candidate enabled by defining INTRA16_PLANE_EN.
module intra16_mode_sched #(
  parameter int ROW_SAMPLES = 16,
  parameter int ROWS        = 16,
  parameter int SAD_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       avail_top,
  input  logic                       avail_left,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [8*ROW_SAMPLES-1:0]   vres_row,
  input  logic [8*ROW_SAMPLES-1:0]   hres_row,
  input  logic [8*ROW_SAMPLES-1:0]   dcres_row,
`ifdef INTRA16_PLANE_EN
  input  logic [8*ROW_SAMPLES-1:0]   pres_row,
  output logic [SAD_W-1:0]           sad_p,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 best_mode,
  output logic [SAD_W-1:0]           best_sad,
  output logic [SAD_W-1:0]           sad_v,
  output logic [SAD_W-1:0]           sad_h,
  output logic [SAD_W-1:0]           sad_dc
);

`ifdef INTRA16_PLANE_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif
  localparam int RSUM_W = 13;
  localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        row_cnt_reg;
  logic                    top_reg, left_reg;
  logic [SAD_W-1:0]        acc_reg [NM];
  logic [1:0]              best_mode_reg;
  logic [SAD_W-1:0]        best_sad_reg;
  logic [8*ROW_SAMPLES-1:0] res [NM];
  logic [RSUM_W-1:0]       row_sum [NM];
  logic [1:0]              win_mode;
  logic [SAD_W-1:0]        win_sad;
  logic                    last_beat;

  // Magnitude taken at 9 bits so that -128 yields 128 rather than wrapping.
  function automatic logic [8:0] abs9(input logic [7:0] s);
    logic [8:0] x;
    x = {s[7], s};
    return s[7] ? 9'(-x) : x;
  endfunction

  assign res[0] = vres_row;
  assign res[1] = hres_row;
  assign res[2] = dcres_row;
`ifdef INTRA16_PLANE_EN
  assign res[3] = pres_row;
`endif

  genvar gm, gi;
  generate
    for (gm = 0; gm < NM; gm++) begin : g_mode
      logic [8:0]        mag [ROW_SAMPLES];
      logic [RSUM_W-1:0] sum;
      for (gi = 0; gi < ROW_SAMPLES; gi++) begin : g_smp
        assign mag[gi] = abs9(res[gm][8*gi +: 8]);
      end
      always_comb begin
        sum = '0;
        for (int k = 0; k < ROW_SAMPLES; k++) begin
          sum = sum + RSUM_W'(mag[k]);
        end
      end
      assign row_sum[gm] = sum;
    end
  endgenerate

  assign last_beat = (row_cnt_reg == CNT_W'(ROWS - 1));

  always_comb begin
    state_next = state_reg;
    row_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM: begin
        row_ready = 1'b1;
        busy      = 1'b1;
        if (row_valid && last_beat) state_next = COMPARE;
      end
      COMPARE: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Candidates are visited from highest to lowest index with <= so ties settle on the lowest index.
  always_comb begin
    win_mode = 2'd2;
    win_sad  = acc_reg[2];
`ifdef INTRA16_PLANE_EN
    if (top_reg && left_reg && (acc_reg[3] < win_sad)) begin
      win_mode = 2'd3;
      win_sad  = acc_reg[3];
    end
`endif
    if (left_reg && (acc_reg[1] <= win_sad)) begin
      win_mode = 2'd1;
      win_sad  = acc_reg[1];
    end
    if (top_reg && (acc_reg[0] <= win_sad)) begin
      win_mode = 2'd0;
      win_sad  = acc_reg[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      row_cnt_reg   <= '0;
      top_reg       <= 1'b0;
      left_reg      <= 1'b0;
      best_mode_reg <= 2'd2;
      best_sad_reg  <= '0;
      for (int m = 0; m < NM; m++) acc_reg[m] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          row_cnt_reg <= '0;
          top_reg     <= avail_top;
          left_reg    <= avail_left;
          for (int m = 0; m < NM; m++) acc_reg[m] <= '0;
        end
        ACCUM: if (row_valid) begin
          row_cnt_reg <= row_cnt_reg + 1'b1;
          for (int m = 0; m < NM; m++) acc_reg[m] <= acc_reg[m] + SAD_W'(row_sum[m]);
        end
        COMPARE: begin
          best_mode_reg <= win_mode;
          best_sad_reg  <= win_sad;
        end
        default: ;
      endcase
    end
  end

  assign best_mode = best_mode_reg;
  assign best_sad  = best_sad_reg;
  assign sad_v     = acc_reg[0];
  assign sad_h     = acc_reg[1];
  assign sad_dc    = acc_reg[2];
`ifdef INTRA16_PLANE_EN
  assign sad_p     = acc_reg[3];
`endif

endmodule

// File: tb/tb_intra16_mode_sched.sv
// Randomised scoreboard bench for intra16_mode_sched: driver pushes model results, monitor checks on done.
module tb_intra16_mode_sched;
  localparam int RS = 16;
  localparam int ROWS = 16;
  localparam int SW = 16;
`ifdef INTRA16_PLANE_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif

  logic clk, reset, start, avail_top, avail_left, row_valid, row_ready;
  logic [8*RS-1:0] vres_row, hres_row, dcres_row;
  logic busy, done;
  logic [1:0] best_mode;
  logic [SW-1:0] best_sad, sad_v, sad_h, sad_dc;
`ifdef INTRA16_PLANE_EN
  logic [8*RS-1:0] pres_row;
  logic [SW-1:0] sad_p;
`endif

  intra16_mode_sched #(.ROW_SAMPLES(RS), .ROWS(ROWS), .SAD_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .avail_top(avail_top), .avail_left(avail_left),
    .row_valid(row_valid), .row_ready(row_ready),
    .vres_row(vres_row), .hres_row(hres_row), .dcres_row(dcres_row),
`ifdef INTRA16_PLANE_EN
    .pres_row(pres_row), .sad_p(sad_p),
`endif
    .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad),
    .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mode;
    int best;
    int sad[4];
    int dcyc;
  } exp_t;
  exp_t q[$];

  int pass_cnt = 0;
  int chk_cnt = 0;
  int mb_id = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        $display("mb result: mode=%0d best=%0d v=%0d h=%0d dc=%0d", best_mode, best_sad, sad_v, sad_h, sad_dc);
        chk("best_mode", best_mode, e.mode);
        chk("best_sad", best_sad, e.best);
        chk("sad_v", sad_v, e.sad[0]);
        chk("sad_h", sad_h, e.sad[1]);
        chk("sad_dc", sad_dc, e.sad[2]);
`ifdef INTRA16_PLANE_EN
        chk("sad_p", sad_p, e.sad[3]);
`endif
        chk("done_latency", cyc, e.dcyc);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // kind 0: constant per-mode values c[]; kind 1: random samples.
  // vmode 0: back-to-back, 1: alternate valid, 2: random valid. abort_after>=0 pulls reset after that many beats.
  task automatic run_mb(input int kind, input int c0, input int c1, input int c2, input int c3,
                        input bit at, input bit al, input int vmode, input bit extra_start,
                        input int abort_after);
    int cv[4];
    int msad[4];
    int rsum[4];
    logic [8*RS-1:0] pk[4];
    int xfers, c, s, bm, bs;
    bit rdy, need_row, cand;
    exp_t e;
    cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
    for (int m = 0; m < 4; m++) msad[m] = 0;
    start = 1'b1; avail_top = at; avail_left = al;
    @(posedge clk); #1;
    start = 1'b0; avail_top = ~at; avail_left = ~al;
    xfers = 0; c = 0; need_row = 1'b1;
    while (xfers < ROWS) begin
      if (abort_after >= 0 && xfers == abort_after) begin
        reset = 1'b0; row_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
      if (need_row) begin
        for (int m = 0; m < 4; m++) begin
          rsum[m] = 0;
          for (int k = 0; k < RS; k++) begin
            s = (kind == 0) ? cv[m] : int'($urandom_range(255)) - 128;
            pk[m][8*k +: 8] = 8'(s);
            rsum[m] += (s < 0) ? -s : s;
          end
        end
        vres_row = pk[0]; hres_row = pk[1]; dcres_row = pk[2];
`ifdef INTRA16_PLANE_EN
        pres_row = pk[3];
`endif
        need_row = 1'b0;
      end
      row_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((c % 2) == 0) : 1'($urandom_range(1));
      start = extra_start && (c == 3);
      @(negedge clk); rdy = row_ready;
      @(posedge clk);
      if (row_valid && rdy) begin
        xfers++;
        for (int m = 0; m < 4; m++) msad[m] += rsum[m];
        need_row = 1'b1;
      end
      #1;
      start = 1'b0;
      c++;
      if (c > 2000) begin
        chk("accum_timeout", xfers, ROWS);
        row_valid = 1'b0;
        return;
      end
    end
    row_valid = 1'b0;
    bm = -1; bs = 0;
    for (int m = 0; m < NM; m++) begin
      cand = (m == 0) ? at : (m == 1) ? al : (m == 2) ? 1'b1 : (at && al);
      if (cand && (bm < 0 || msad[m] < bs)) begin bm = m; bs = msad[m]; end
    end
    e.mode = bm; e.best = bs; e.dcyc = cyc + 1;
    for (int m = 0; m < 4; m++) e.sad[m] = msad[m];
    q.push_back(e);
    $display("mb %0d issued: at=%0d al=%0d vmode=%0d exp_mode=%0d exp_best=%0d", mb_id, at, al, vmode, bm, bs);
    mb_id++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; avail_top = 1'b0; avail_left = 1'b0; row_valid = 1'b0;
    vres_row = '0; hres_row = '0; dcres_row = '0;
`ifdef INTRA16_PLANE_EN
    pres_row = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_ready", row_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_best_mode", best_mode, 2);
    chk("rst_best_sad", best_sad, 0);
    chk("rst_sad_v", sad_v, 0);
    chk("rst_sad_h", sad_h, 0);
    chk("rst_sad_dc", sad_dc, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_mb(0, 0, 0, 0, 0, 1, 1, 0, 0, -1);
    run_mb(0, 3, -1, 2, 5, 1, 1, 0, 0, -1);
    run_mb(0, -128, -128, -128, -128, 1, 1, 0, 0, -1);
    run_mb(0, 3, -1, 2, 5, 1, 0, 0, 0, -1);
    run_mb(0, 3, -1, 2, 5, 0, 0, 0, 0, -1);
    run_mb(0, 3, -1, 2, 5, 1, 1, 1, 1, -1);
    chk("ignored_idle_row_ready", row_ready, 0);

    run_mb(1, 0, 0, 0, 0, 1, 1, 0, 0, 7);
    chk("abort_sad_v", sad_v, 0);
    chk("abort_busy", busy, 0);
    chk("abort_best_mode", best_mode, 2);
    run_mb(0, 1, 2, 1, 1, 1, 1, 0, 0, -1);

    for (int i = 0; i < 10; i++)
      run_mb(1, 0, 0, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
             int'($urandom_range(2)), 1'($urandom_range(1)), -1);

    chk("pending_results", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
